// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory controller: RV32I funct3 codes,
// FSM state encoding, arbiter grant encoding and the access legality check.
package dmem_pkg;

    // Load funct3 codes
    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    // Store funct3 codes
    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WRITE  = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    typedef enum logic {
        GRANT_CORE = 1'b0,
        GRANT_DBG  = 1'b1
    } grant_e;

    // True when the access must not touch memory: bad funct3, misaligned
    // half/word, or a word index beyond the memory depth.
    function automatic logic access_illegal(
        input logic        we,
        input logic [2:0]  funct3,
        input logic [31:0] addr,
        input int unsigned depth_log2
    );
        logic bad;
        bad = 1'b0;
        if (we) begin
            if (funct3 > F3_SW) bad = 1'b1;
        end else begin
            if (funct3 == 3'd3 || funct3 == 3'd6 || funct3 == 3'd7) bad = 1'b1;
        end
        // Halfword codes (1, 5) need addr[0]=0; word code (2) needs addr[1:0]=0
        if (funct3[1:0] == 2'b01 && addr[0]) bad = 1'b1;
        if (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00) bad = 1'b1;
        if ({2'b00, addr[31:2]} >= (32'd1 << depth_log2)) bad = 1'b1;
        return bad;
    endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// Bus bundle between the data-memory controller, its requesters and the
// word-wide memory. Debug-port signals exist only when DBG_PORT_EN is defined.
interface dmem_ctrl_if;

    // Core LSU side
    logic        core_req_in;
    logic        core_we_in;
    logic [2:0]  core_funct3_in;
    logic [31:0] core_addr_in;
    logic [31:0] core_wdata_in;
    logic        core_ack_out;
    logic [31:0] core_rdata_out;
    logic        core_err_out;
`ifdef DBG_PORT_EN
    // Debug side (word accesses only)
    logic        dbg_req_in;
    logic        dbg_we_in;
    logic [31:0] dbg_addr_in;
    logic [31:0] dbg_wdata_in;
    logic        dbg_ack_out;
    logic [31:0] dbg_rdata_out;
    logic        dbg_err_out;
`endif
    // Memory side
    logic [31:0] mem_rd_addr_out;
    logic [31:0] mem_rd_data_in;
    logic        mem_wr_en_out;
    logic [31:0] mem_wr_addr_out;
    logic [31:0] mem_wr_data_out;
    logic        busy_out;

`ifdef DBG_PORT_EN
    modport slave (
        input  core_req_in, core_we_in, core_funct3_in, core_addr_in, core_wdata_in,
        output core_ack_out, core_rdata_out, core_err_out,
        input  dbg_req_in, dbg_we_in, dbg_addr_in, dbg_wdata_in,
        output dbg_ack_out, dbg_rdata_out, dbg_err_out,
        output mem_rd_addr_out, input mem_rd_data_in,
        output mem_wr_en_out, mem_wr_addr_out, mem_wr_data_out, busy_out
    );
    modport master (
        output core_req_in, core_we_in, core_funct3_in, core_addr_in, core_wdata_in,
        input  core_ack_out, core_rdata_out, core_err_out,
        output dbg_req_in, dbg_we_in, dbg_addr_in, dbg_wdata_in,
        input  dbg_ack_out, dbg_rdata_out, dbg_err_out,
        input  mem_rd_addr_out, output mem_rd_data_in,
        input  mem_wr_en_out, mem_wr_addr_out, mem_wr_data_out, busy_out
    );
`else
    modport slave (
        input  core_req_in, core_we_in, core_funct3_in, core_addr_in, core_wdata_in,
        output core_ack_out, core_rdata_out, core_err_out,
        output mem_rd_addr_out, input mem_rd_data_in,
        output mem_wr_en_out, mem_wr_addr_out, mem_wr_data_out, busy_out
    );
    modport master (
        output core_req_in, core_we_in, core_funct3_in, core_addr_in, core_wdata_in,
        input  core_ack_out, core_rdata_out, core_err_out,
        input  mem_rd_addr_out, output mem_rd_data_in,
        input  mem_wr_en_out, mem_wr_addr_out, mem_wr_data_out, busy_out
    );
`endif

endinterface

// File: rtl/dmem_lane_align.sv
// Combinational lane logic: extracts and extends the addressed byte/half of a
// memory word for loads, and builds the merged word for SB/SH.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  funct3_in,
    input  logic [1:0]  addr_lo_in,
    input  logic [31:0] mem_word_in,
    input  logic [31:0] store_data_in,
    output logic [31:0] load_data_out,
    output logic [31:0] merged_word_out
);

    logic [31:0] byte_shifted;
    logic [31:0] half_shifted;
    logic [31:0] lane_mask;
    logic [31:0] store_shifted;

    // Load path: shift the addressed lane down to bit 0 and extend it
    always_comb begin
        byte_shifted = mem_word_in >> {addr_lo_in, 3'b000};
        half_shifted = mem_word_in >> {addr_lo_in[1], 4'b0000};
        unique case (funct3_in)
            F3_LB:   load_data_out = {{24{byte_shifted[7]}}, byte_shifted[7:0]};
            F3_LH:   load_data_out = {{16{half_shifted[15]}}, half_shifted[15:0]};
            F3_LBU:  load_data_out = {24'h0, byte_shifted[7:0]};
            F3_LHU:  load_data_out = {16'h0, half_shifted[15:0]};
            default: load_data_out = mem_word_in;
        endcase
    end

    // Store path: replace only the addressed lane of the old word
    always_comb begin
        store_shifted = store_data_in << {addr_lo_in, 3'b000};
        unique case (funct3_in)
            F3_SB:   lane_mask = 32'h0000_00FF << {addr_lo_in, 3'b000};
            F3_SH:   lane_mask = 32'h0000_FFFF << {addr_lo_in[1], 4'b0000};
            default: lane_mask = 32'h0;
        endcase
        merged_word_out = (mem_word_in & ~lane_mask) | (store_shifted & lane_mask);
    end

endmodule

// File: rtl/dmem_ctrl.sv
// RV32I data-memory controller: sequences loads/stores onto a word memory with
// combinational read and synchronous write, handles lane extraction and
// read-modify-write for SB/SH, and flags illegal accesses.
// Optional feature macro: DBG_PORT_EN (adds a word-only debug port and a
// round-robin arbiter between core and debug).
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 8
) (
    input logic        clkin,
    input logic        rst_in,
    dmem_ctrl_if.slave bus
);

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] merge_q, merge_d;
    logic [31:0] rd_addr_q, rd_addr_d;
    logic        err_q, err_d;
`ifdef DBG_PORT_EN
    grant_e      grant_q, grant_d;
    grant_e      last_grant_q, last_grant_d;
    logic        sel_dbg;
`endif

    logic        any_req;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_illegal;

    logic        done_ack;
    logic        core_sel;
    logic        wr_en;
    logic [31:0] wr_data;
    logic [31:0] rd_addr;
    logic [31:0] word_idx;
    logic [31:0] load_data;
    logic [31:0] merged_word;

    assign word_idx = {2'b00, addr_q[31:2]};

    dmem_lane_align u_lane_align (
        .funct3_in       (funct3_q),
        .addr_lo_in      (addr_q[1:0]),
        .mem_word_in     (bus.mem_rd_data_in),
        .store_data_in   (wdata_q),
        .load_data_out   (load_data),
        .merged_word_out (merged_word)
    );

    // Request selection: pick the winning requester and check its legality
    always_comb begin
`ifdef DBG_PORT_EN
        any_req = bus.core_req_in | bus.dbg_req_in;
        sel_dbg = bus.dbg_req_in & (~bus.core_req_in | (last_grant_q == GRANT_CORE));
        if (sel_dbg) begin
            req_we     = bus.dbg_we_in;
            req_funct3 = F3_SW;
            req_addr   = bus.dbg_addr_in;
            req_wdata  = bus.dbg_wdata_in;
        end else begin
            req_we     = bus.core_we_in;
            req_funct3 = bus.core_funct3_in;
            req_addr   = bus.core_addr_in;
            req_wdata  = bus.core_wdata_in;
        end
`else
        any_req    = bus.core_req_in;
        req_we     = bus.core_we_in;
        req_funct3 = bus.core_funct3_in;
        req_addr   = bus.core_addr_in;
        req_wdata  = bus.core_wdata_in;
`endif
        req_illegal = access_illegal(req_we, req_funct3, req_addr, DEPTH_LOG2);
    end

    // FSM next-state and memory-side outputs
    always_comb begin
        // NOTE: every signal gets a default first, so no branch can infer a latch.
        state_d   = state_q;
        we_d      = we_q;
        funct3_d  = funct3_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        merge_d   = merge_q;
        rd_addr_d = rd_addr_q;
        err_d     = err_q;
`ifdef DBG_PORT_EN
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
`endif
        done_ack = 1'b0;
        wr_en    = 1'b0;
        wr_data  = 32'h0;
        rd_addr  = rd_addr_q;

        unique case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    we_d     = req_we;
                    funct3_d = req_funct3;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    err_d    = req_illegal;
                    rdata_d  = 32'h0;
`ifdef DBG_PORT_EN
                    grant_d      = sel_dbg ? GRANT_DBG : GRANT_CORE;
                    last_grant_d = sel_dbg ? GRANT_DBG : GRANT_CORE;
`endif
                    state_d  = req_illegal ? ST_DONE : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                rd_addr   = word_idx;
                rd_addr_d = word_idx;
                if (!we_q) begin
                    rdata_d = load_data;
                    state_d = ST_DONE;
                end else if (funct3_q == F3_SW) begin
                    wr_en   = 1'b1;
                    wr_data = wdata_q;
                    state_d = ST_DONE;
                end else begin
                    merge_d = merged_word;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                wr_en   = 1'b1;
                wr_data = merge_q;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                done_ack = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and transaction registers; reset aborts any access in flight
    always_ff @(posedge clkin or posedge rst_in) begin
        if (rst_in) begin
            state_q   <= ST_IDLE;
            we_q      <= 1'b0;
            funct3_q  <= 3'd0;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            rdata_q   <= 32'h0;
            merge_q   <= 32'h0;
            rd_addr_q <= 32'h0;
            err_q     <= 1'b0;
`ifdef DBG_PORT_EN
            grant_q      <= GRANT_CORE;
            last_grant_q <= GRANT_DBG;
`endif
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            state_q   <= state_d;
            we_q      <= we_d;
            funct3_q  <= funct3_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            merge_q   <= merge_d;
            rd_addr_q <= rd_addr_d;
            err_q     <= err_d;
`ifdef DBG_PORT_EN
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
`endif
        end
    end

`ifdef DBG_PORT_EN
    assign core_sel = (grant_q == GRANT_CORE);
    assign bus.dbg_ack_out   = done_ack & ~core_sel;
    assign bus.dbg_rdata_out = (done_ack & ~core_sel) ? rdata_q : 32'h0;
    assign bus.dbg_err_out   = done_ack & ~core_sel & err_q;
`else
    assign core_sel = 1'b1;
`endif

    assign bus.core_ack_out    = done_ack & core_sel;
    assign bus.core_rdata_out  = (done_ack & core_sel) ? rdata_q : 32'h0;
    assign bus.core_err_out    = done_ack & core_sel & err_q;
    assign bus.mem_rd_addr_out = rd_addr;
    assign bus.mem_wr_en_out   = wr_en;
    assign bus.mem_wr_addr_out = wr_en ? word_idx : 32'h0;
    assign bus.mem_wr_data_out = wr_data;
    assign bus.busy_out        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: table-driven core accesses with a
// scoreboard queue, plus hand sequences for reset-in-WRITE, back-to-back
// access and (with DBG_PORT_EN) round-robin arbitration.
module tb_dmem_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmem_ctrl_if bus ();

    dmem_ctrl #(.DEPTH_LOG2(8)) dut (
        .clkin  (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    // Memory model: combinational read, synchronous write
    logic [31:0] mem [0:255];
    int          wr_cnt = 0;
    assign bus.mem_rd_data_in = mem[bus.mem_rd_addr_out[7:0]];
    always @(posedge clk) begin
        if (bus.mem_wr_en_out) begin
            mem[bus.mem_wr_addr_out[7:0]] <= bus.mem_wr_data_out;
            wr_cnt++;
        end
    end

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        string       tag;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } vec_t;
    localparam int NV = 19;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic wait_core_ack();
        int   cyc;
        bit   got;
        exp_t e;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 16) begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.core_ack_out) got = 1'b1;
        end
        e = sb_q.pop_front();
        if (!got) begin
            tests_run++;
            tests_failed++;
            $display("FAIL %s_timeout: no ack within %0d cycles", e.tag, cyc);
        end else begin
            check({e.tag, "_rdata"}, bus.core_rdata_out, e.rdata);
            check({e.tag, "_err"}, {31'h0, bus.core_err_out}, {31'h0, e.err});
            check({e.tag, "_lat"}, cyc, e.lat);
        end
    endtask

    task automatic drive_core(input logic we, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata);
        bus.core_req_in    = 1'b1;
        bus.core_we_in     = we;
        bus.core_funct3_in = f3;
        bus.core_addr_in   = addr;
        bus.core_wdata_in  = wdata;
    endtask

    task automatic core_access(input vec_t v, input string tag);
        exp_t e;
        drive_core(v.we, v.f3, v.addr, v.wdata);
        e.rdata = v.rdata;
        e.err   = v.err;
        e.lat   = v.lat;
        e.tag   = tag;
        sb_q.push_back(e);
        wait_core_ack();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   w0;
        exp_t e;
        vec_t v;

        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[4]   = 32'h8899AABB;
        mem[255] = 32'hCAFE8001;

        bus.core_req_in    = 1'b0;
        bus.core_we_in     = 1'b0;
        bus.core_funct3_in = 3'd0;
        bus.core_addr_in   = 32'h0;
        bus.core_wdata_in  = 32'h0;
`ifdef DBG_PORT_EN
        bus.dbg_req_in   = 1'b0;
        bus.dbg_we_in    = 1'b0;
        bus.dbg_addr_in  = 32'h0;
        bus.dbg_wdata_in = 32'h0;
`endif

        //            we  f3    addr          wdata         rdata         err lat
        vecs[0]  = '{1'b0, 3'd0, 32'h11,  32'h0,        32'hFFFFFFAA, 1'b0, 2}; // LB
        vecs[1]  = '{1'b0, 3'd4, 32'h11,  32'h0,        32'h000000AA, 1'b0, 2}; // LBU
        vecs[2]  = '{1'b0, 3'd5, 32'h12,  32'h0,        32'h00008899, 1'b0, 2}; // LHU
        vecs[3]  = '{1'b0, 3'd1, 32'h10,  32'h0,        32'hFFFFAABB, 1'b0, 2}; // LH
        vecs[4]  = '{1'b0, 3'd2, 32'h10,  32'h0,        32'h8899AABB, 1'b0, 2}; // LW
        vecs[5]  = '{1'b1, 3'd0, 32'h12,  32'hFFFFFF5C, 32'h0,        1'b0, 3}; // SB
        vecs[6]  = '{1'b0, 3'd2, 32'h10,  32'h0,        32'h885CAABB, 1'b0, 2}; // LW
        vecs[7]  = '{1'b1, 3'd1, 32'h10,  32'hABCD1234, 32'h0,        1'b0, 3}; // SH
        vecs[8]  = '{1'b0, 3'd2, 32'h10,  32'h0,        32'h885C1234, 1'b0, 2}; // LW
        vecs[9]  = '{1'b0, 3'd0, 32'h13,  32'h0,        32'hFFFFFF88, 1'b0, 2}; // LB top lane
        vecs[10] = '{1'b0, 3'd2, 32'h13,  32'h0,        32'h0,        1'b1, 1}; // LW misaligned
        vecs[11] = '{1'b1, 3'd1, 32'h11,  32'h5555,     32'h0,        1'b1, 1}; // SH misaligned
        vecs[12] = '{1'b0, 3'd3, 32'h10,  32'h0,        32'h0,        1'b1, 1}; // bad load f3
        vecs[13] = '{1'b0, 3'd2, 32'h400, 32'h0,        32'h0,        1'b1, 1}; // out of range
        vecs[14] = '{1'b1, 3'd3, 32'h10,  32'h0,        32'h0,        1'b1, 1}; // bad store f3
        vecs[15] = '{1'b0, 3'd2, 32'h10,  32'h0,        32'h885C1234, 1'b0, 2}; // unchanged
        vecs[16] = '{1'b0, 3'd5, 32'h3FE, 32'h0,        32'h0000CAFE, 1'b0, 2}; // last word
        vecs[17] = '{1'b0, 3'd0, 32'h3FC, 32'h0,        32'h00000001, 1'b0, 2}; // last word
        vecs[18] = '{1'b0, 3'd2, 32'h3FC, 32'h0,        32'hCAFE8001, 1'b0, 2}; // last word

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack",     {31'h0, bus.core_ack_out}, 32'h0);
        check("rst_rdata",   bus.core_rdata_out, 32'h0);
        check("rst_err",     {31'h0, bus.core_err_out}, 32'h0);
        check("rst_busy",    {31'h0, bus.busy_out}, 32'h0);
        check("rst_wr_en",   {31'h0, bus.mem_wr_en_out}, 32'h0);
        check("rst_wr_addr", bus.mem_wr_addr_out, 32'h0);
        check("rst_wr_data", bus.mem_wr_data_out, 32'h0);
        check("rst_rd_addr", bus.mem_rd_addr_out, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Table-driven accesses
        for (int i = 0; i < NV; i++) begin
            w0 = wr_cnt;
            core_access(vecs[i], $sformatf("v%0d", i));
            check($sformatf("v%0d_writes", i), wr_cnt - w0,
                  (vecs[i].we && !vecs[i].err) ? 32'd1 : 32'd0);
            bus.core_req_in = 1'b0;
            @(posedge clk);
            #1;
            check($sformatf("v%0d_ack_pulse", i), {31'h0, bus.core_ack_out}, 32'h0);
        end

        // Reset during the WRITE cycle of an SB
        drive_core(1'b1, 3'd0, 32'h10, 32'h77);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("rstw_in_write", {31'h0, bus.mem_wr_en_out}, 32'h1);
        rst = 1'b1;
        #1;
        check("rstw_wr_en", {31'h0, bus.mem_wr_en_out}, 32'h0);
        check("rstw_busy",  {31'h0, bus.busy_out}, 32'h0);
        bus.core_req_in = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rstw_mem", mem[4], 32'h885C1234);
        check("rstw_idle", {31'h0, bus.busy_out}, 32'h0);

        // Back-to-back SW then LW on the same word
        v = '{1'b1, 3'd2, 32'h20, 32'hDEADBEEF, 32'h0, 1'b0, 2};
        core_access(v, "b2b_sw");
        drive_core(1'b0, 3'd2, 32'h20, 32'h0);
        @(posedge clk);
        #1;
        check("b2b_idle_busy", {31'h0, bus.busy_out}, 32'h0);
        check("b2b_idle_ack",  {31'h0, bus.core_ack_out}, 32'h0);
        @(posedge clk);
        #1;
        check("b2b_grant_busy", {31'h0, bus.busy_out}, 32'h1);
        check("b2b_rd_addr",    bus.mem_rd_addr_out, 32'h8);
        e.rdata = 32'hDEADBEEF;
        e.err   = 1'b0;
        e.lat   = 1;
        e.tag   = "b2b_lw";
        sb_q.push_back(e);
        wait_core_ack();
        bus.core_req_in = 1'b0;
        @(posedge clk);
        #1;
        check("b2b_mem", mem[8], 32'hDEADBEEF);

`ifdef DBG_PORT_EN
        // Continuous contention: grants alternate, starting with core
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        drive_core(1'b0, 3'd2, 32'h10, 32'h0);
        bus.dbg_req_in   = 1'b1;
        bus.dbg_we_in    = 1'b0;
        bus.dbg_addr_in  = 32'h20;
        bus.dbg_wdata_in = 32'h0;
        for (int k = 0; k < 6; k++) begin
            int cyc;
            cyc = 0;
            while (!(bus.core_ack_out || bus.dbg_ack_out) && cyc < 16) begin
                @(posedge clk);
                #1;
                cyc++;
            end
            if (cyc >= 16) begin
                tests_run++;
                tests_failed++;
                $display("FAIL rr%0d_timeout: no ack", k);
            end else begin
                check($sformatf("rr%0d_core_ack", k), {31'h0, bus.core_ack_out},
                      (k % 2 == 0) ? 32'h1 : 32'h0);
                check($sformatf("rr%0d_dbg_ack", k), {31'h0, bus.dbg_ack_out},
                      (k % 2 == 0) ? 32'h0 : 32'h1);
                if (k % 2 == 0)
                    check($sformatf("rr%0d_rdata", k), bus.core_rdata_out, 32'h885C1234);
                else
                    check($sformatf("rr%0d_rdata", k), bus.dbg_rdata_out, 32'hDEADBEEF);
                @(posedge clk);
                #1;
                check($sformatf("rr%0d_pulse", k),
                      {30'h0, bus.core_ack_out, bus.dbg_ack_out}, 32'h0);
            end
        end
        bus.core_req_in = 1'b0;
        bus.dbg_req_in  = 1'b0;
        repeat (3) @(posedge clk);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
